// File: rtl/alu.sv
// alu: two-operand ALU with a combinational result/flag path and two
// independently loaded output registers.
//
// Ports:
//   clk      - clock; registers update on the rising edge
//   rst_n    - asynchronous active-low reset; clears C and status
//   val_A    - operand A
//   val_B    - operand B
//   ALU_op   - 00 add, 01 sub, 10 AND, 11 NOT B
//   load_c   - capture ALU_out into C
//   load_s   - capture {Z,N,V} into status
//   ALU_out  - combinational result
//   Z, N, V  - combinational zero / negative / signed-overflow flags
//   C        - registered result
//   status   - registered flags {Z,N,V}
module alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] val_A,
  input  logic [WIDTH-1:0] val_B,
  input  logic [1:0]       ALU_op,
  input  logic             load_c,
  input  logic             load_s,
  output logic [WIDTH-1:0] ALU_out,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic [WIDTH-1:0] C,
  output logic [2:0]       status
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAnd = 2'b10;
  localparam logic [1:0] OpNot = 2'b11;

  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             a_msb, b_msb, r_msb;

  logic [WIDTH-1:0] c_d, c_q;
  logic [2:0]       status_d, status_q;

  assign a_msb = val_A[WIDTH-1];
  assign b_msb = val_B[WIDTH-1];
  assign r_msb = result[WIDTH-1];

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    unique case (ALU_op)
      OpAdd: begin
        result = val_A + val_B;
        // Same-sign operands producing a result of the other sign.
        ovf    = (a_msb == b_msb) && (r_msb != a_msb);
      end
      OpSub: begin
        result = val_A - val_B;
        // Opposite-sign operands producing a result whose sign differs from A.
        ovf    = (a_msb != b_msb) && (r_msb != a_msb);
      end
      OpAnd: result = val_A & val_B;
      OpNot: result = ~val_B;
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

  assign ALU_out = result;
  assign Z       = (result == '0);
  assign N       = r_msb;
  assign V       = ovf;

  always_comb begin
    c_d      = load_c ? result : c_q;
    status_d = load_s ? {Z, N, V} : status_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q      <= '0;
      status_q <= 3'b000;
    end else begin
      c_q      <= c_d;
      status_q <= status_d;
    end
  end

  assign C      = c_q;
  assign status = status_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu (WIDTH=16). Directed vectors followed by
// randomized operations, compared against an integer-arithmetic reference.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] val_A;
  logic [15:0] val_B;
  logic [1:0]  ALU_op;
  logic        load_c;
  logic        load_s;
  logic [15:0] ALU_out;
  logic        Z;
  logic        N;
  logic        V;
  logic [15:0] C;
  logic [2:0]  status;

  int n_checks;
  int n_fail;

  // Reference copies of the two output registers.
  logic [15:0] exp_c;
  logic [2:0]  exp_s;

  alu #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .val_A   (val_A),
    .val_B   (val_B),
    .ALU_op  (ALU_op),
    .load_c  (load_c),
    .load_s  (load_s),
    .ALU_out (ALU_out),
    .Z       (Z),
    .N       (N),
    .V       (V),
    .C       (C),
    .status  (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_signed16(input int u);
    return (u >= 32768) ? u - 65536 : u;
  endfunction

  // Reference: plain integer arithmetic over the operation definitions.
  task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic z, output logic n,
                       output logic v);
    int ia, ib, res, sres;
    ia = int'(a);
    ib = int'(b);
    v  = 1'b0;
    case (op)
      2'd0: begin
        res  = (ia + ib) % 65536;
        sres = to_signed16(ia) + to_signed16(ib);
        v    = (sres > 32767) || (sres < -32768);
      end
      2'd1: begin
        res  = (ia - ib + 65536) % 65536;
        sres = to_signed16(ia) - to_signed16(ib);
        v    = (sres > 32767) || (sres < -32768);
      end
      2'd2: res = int'(a & b);
      default: res = 65535 - ib;
    endcase
    r = res[15:0];
    z = (res == 0);
    n = (res >= 32768);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive operands and verify the combinational outputs against the model.
  task automatic apply(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input string tag);
    logic [15:0] r;
    logic z, n, v;
    ALU_op = op;
    val_A  = a;
    val_B  = b;
    #1;
    model(op, a, b, r, z, n, v);
    check({tag, " out"}, 32'(ALU_out), 32'(r));
    check({tag, " Z"},   32'(Z),       32'(z));
    check({tag, " N"},   32'(N),       32'(n));
    check({tag, " V"},   32'(V),       32'(v));
  endtask

  // Clock the current inputs in and verify the registers; called from negedge.
  task automatic clock_regs(input string tag);
    logic [15:0] r;
    logic z, n, v;
    model(ALU_op, val_A, val_B, r, z, n, v);
    if (load_c) exp_c = r;
    if (load_s) exp_s = {z, n, v};
    @(posedge clk);
    #1;
    check({tag, " C"},      32'(C),      32'(exp_c));
    check({tag, " status"}, 32'(status), 32'(exp_s));
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    val_A    = '0;
    val_B    = '0;
    ALU_op   = 2'b00;
    load_c   = 1'b1;
    load_s   = 1'b1;
    exp_c    = '0;
    exp_s    = '0;

    // Reset holds registers at zero even with loads asserted across edges.
    repeat (2) @(posedge clk);
    #1;
    check("reset C", 32'(C), 32'h0);
    check("reset status", 32'(status), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    load_c = 1'b0;
    load_s = 1'b0;

    // Directed combinational vectors.
    for (int op = 0; op < 4; op++) apply(2'(op), 16'd0, 16'd0, "zero");
    check("zero NOT out", 32'(ALU_out), 32'hFFFF);
    for (int op = 0; op < 4; op++) apply(2'(op), 16'd10, 16'd11, "10_11");
    apply(2'b01, 16'd10, 16'd11, "10-11");
    check("10-11 literal", 32'(ALU_out), 32'hFFFF);
    for (int op = 0; op < 4; op++) apply(2'(op), 16'd13, 16'd4, "13_4");
    apply(2'b11, 16'd13, 16'd4, "not4");
    check("not4 literal", 32'(ALU_out), 32'hFFFB);
    apply(2'b00, 16'h7FFF, 16'h0001, "add ovf");
    check("add ovf V literal", 32'(V), 32'h1);
    apply(2'b01, 16'h8000, 16'h0001, "sub ovf");
    check("sub ovf out literal", 32'(ALU_out), 32'h7FFF);
    apply(2'b01, 16'h0000, 16'h8000, "sub min");
    apply(2'b00, 16'h8000, 16'h8000, "add neg ovf");

    // Capture 5-5 into both registers, then hold with loads off.
    @(negedge clk);
    apply(2'b01, 16'd5, 16'd5, "5-5");
    load_c = 1'b1;
    load_s = 1'b1;
    clock_regs("5-5 load");
    check("5-5 status literal", 32'(status), 32'b100);
    load_c = 1'b0;
    load_s = 1'b0;
    apply(2'b00, 16'h7FFF, 16'h0001, "hold in");
    clock_regs("hold");
    check("hold C literal", 32'(C), 32'h0);

    // Independent loads: only one register moves.
    load_c = 1'b1;
    clock_regs("only c");
    load_c = 1'b0;
    load_s = 1'b1;
    apply(2'b11, 16'h1234, 16'h0000, "only s in");
    clock_regs("only s");
    load_s = 1'b0;

    // Randomized operations with random load enables.
    for (int i = 0; i < 300; i++) begin
      apply(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), "rand");
      load_c = 1'($urandom);
      load_s = 1'($urandom);
      clock_regs("rand");
    end

    // Load C=0015, then reset mid-cycle without any clock edge.
    apply(2'b00, 16'd10, 16'd11, "pre-rst");
    load_c = 1'b1;
    load_s = 1'b1;
    clock_regs("pre-rst");
    check("pre-rst C literal", 32'(C), 32'h0015);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst C", 32'(C), 32'h0);
    check("async rst status", 32'(status), 32'h0);
    exp_c = '0;
    exp_s = '0;
    apply(2'b11, 16'h0000, 16'h00FF, "comb in rst");
    @(posedge clk);
    #1;
    check("rst override C", 32'(C), 32'h0);
    check("rst override status", 32'(status), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clock_regs("post-rst");
    check("post-rst C literal", 32'(C), 32'hFF00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
